vector_memory_access: RTL and testbench
=======================================

VECTOR_MEMORY_ACCESS -- requirements
Module: vector_memory_access

Interface
REQ-001 SHALL provide parameter LANES, default 8, number of vector elements.
REQ-002 SHALL provide parameter ELEM_W, default 24, element width in bits (8x24 = 192-bit vector).
REQ-003 SHALL provide parameter DEPTH, default 1024, memory depth in elements; power of two only.
REQ-004 SHALL provide parameter BEAT_ELEMS, default 2, elements moved per cycle; must divide LANES.
REQ-005 SHALL provide port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port req, input, 1, access request.
REQ-008 SHALL provide port we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL provide port vecOp, input, 1, 1 = vector access, 0 = scalar access.
REQ-010 SHALL provide port address, input, clog2(DEPTH), element base address.
REQ-011 SHALL provide port wdv, input, LANES*ELEM_W, vector write data; lane i = wdv[i*ELEM_W +: ELEM_W].
REQ-012 SHALL provide port wds, input, ELEM_W, scalar write data.
REQ-013 SHALL provide port busy, output, 1, vector transfer in progress.
REQ-014 SHALL provide port done, output, 1, single-cycle completion pulse.
REQ-015 SHALL provide port rdv, output, LANES*ELEM_W, vector read data.
REQ-016 SHALL provide port rds, output, ELEM_W, scalar read data.
REQ-017 SHALL provide port err, output, 1, bounds-error pulse, coincident with done.

Function
REQ-018 SHALL hold an internal DEPTH x ELEM_W array; array contents are not reset.
REQ-019 SHALL accept a request on a rising edge where req=1 and busy=0; it SHALL latch we, vecOp, address, wdv and wds on that edge.
REQ-020 SHALL ignore req while busy=1: no queuing, no side effects.
REQ-021 Scalar access SHALL complete at the acceptance edge (write to mem[address], or rds <= mem[address]); done=1 the following cycle; busy stays 0, so back-to-back scalar requests are accepted every cycle.
REQ-022 FSM SHALL have states IDLE and VEC; a vector acceptance SHALL move it IDLE->VEC, set busy=1 and clear beat counter to 0.
REQ-023 In VEC, each cycle SHALL transfer lanes beat*BEAT_ELEMS .. beat*BEAT_ELEMS+BEAT_ELEMS-1; lane i uses element address (address+i) mod DEPTH.
REQ-024 After beat LANES/BEAT_ELEMS-1 the FSM SHALL return to IDLE; busy drops and done pulses in the next cycle, giving latency LANES/BEAT_ELEMS+1 cycles from acceptance to done.
REQ-025 A vector read SHALL update rdv lanes as their beats complete; rdv and rds SHALL hold their values until the next read of the same kind.
REQ-026 A read accepted after a write's done SHALL return the written data.

Reset
REQ-027 rst_n=0 SHALL asynchronously force FSM=IDLE, beat=0, busy=0, done=0, err=0, rdv=0, rds=0.
REQ-028 A reset during VEC SHALL abort the transfer; beats already written remain in memory, remaining lanes are untouched, and a request is accepted on the first edge after release.

Configuration
REQ-029 With MEM_ACCESS_BOUNDS_CHECK_EN defined, a vector request with address+LANES-1 >= DEPTH SHALL be rejected: no memory or rdv change, busy stays 0, and done=1 and err=1 one cycle after acceptance.
REQ-030 Without MEM_ACCESS_BOUNDS_CHECK_EN, vector addresses SHALL wrap modulo DEPTH and err SHALL be tied to 0.

Verification (LANES=8, ELEM_W=24, DEPTH=1024, BEAT_ELEMS=2)
REQ-031 Scalar write wds=0x00ABCD at address 5, then scalar read at address 5 -> rds=0x00ABCD; done one cycle after each acceptance; busy never 1.
REQ-032 Vector write lanes 0x000001..0x000008 at base 16 -> busy=1 for 4 cycles, done in cycle 5; vector read at base 16 -> identical rdv; scalar read at address 19 -> rds=0x000004.
REQ-033 Request we=1, address 100 issued while busy -> ignored; mem[100] unchanged, no extra done.
REQ-034 Vector write at base 1020 -> without macro, lanes 4..7 land at 0..3; with macro, err=1 and done=1 after 1 cycle, busy=0, memory unchanged.
REQ-035 rst_n pulsed low after 2 beats of a vector write at base 32 -> busy, done, rdv, rds = 0 immediately; mem[32..35] written, mem[36..39] unchanged; next request accepted.

Source files
------------

// File: rtl/vector_memory_access_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_memory_access_if                                            |
// | Request/response bundle for the vector memory access block.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface vector_memory_access_if #(
  parameter int LANES  = 8,
  parameter int ELEM_W = 24,
  parameter int DEPTH  = 1024
) ();
  logic                       req;
  logic                       we;
  logic                       vecOp;
  logic [$clog2(DEPTH)-1:0]   address;
  logic [LANES*ELEM_W-1:0]    wdv;
  logic [ELEM_W-1:0]          wds;
  logic                       busy;
  logic                       done;
  logic [LANES*ELEM_W-1:0]    rdv;
  logic [ELEM_W-1:0]          rds;
  logic                       err;

  modport master (
    output req, we, vecOp, address, wdv, wds,
    input  busy, done, rdv, rds, err
  );

  modport slave (
    input  req, we, vecOp, address, wdv, wds,
    output busy, done, rdv, rds, err
  );
endinterface
`default_nettype wire

// File: rtl/vector_memory_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_memory_access                                               |
// | Element memory with single-cycle scalar and multi-beat vector      |
// | access. Optional MEM_ACCESS_BOUNDS_CHECK_EN rejects vector         |
// | requests running past the end of memory instead of wrapping.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vector_memory_access #(
  parameter int LANES      = 8,
  parameter int ELEM_W     = 24,
  parameter int DEPTH      = 1024,
  parameter int BEAT_ELEMS = 2
) (
  input wire logic                clk,
  input wire logic                rst_n,
  vector_memory_access_if.slave   bus
);

  localparam int c_AW   = $clog2(DEPTH);
  localparam int c_NB   = LANES / BEAT_ELEMS;
  localparam int c_BW   = (c_NB > 1) ? $clog2(c_NB) : 1;
  localparam int c_LIW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [c_BW-1:0] c_LAST = c_BW'(c_NB - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_VEC  = 1'b1
  } state_t;

  logic [ELEM_W-1:0]             r_mem [DEPTH];
  state_t                        r_state;
  logic [c_BW-1:0]               r_beat;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_err;
  logic                          r_we;
  logic [c_AW-1:0]               r_addr;
  logic [LANES-1:0][ELEM_W-1:0]  r_wdv;
  logic [LANES-1:0][ELEM_W-1:0]  r_rdv;
  logic [ELEM_W-1:0]             r_rds;

  logic                          w_acc;
  logic                          w_oob;
  logic [c_LIW-1:0]              w_lane [BEAT_ELEMS];
  logic [c_AW-1:0]               w_ea   [BEAT_ELEMS];

  assign w_acc = bus.req && !r_busy;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign w_oob = (int'(bus.address) + LANES - 1) >= DEPTH;
`else
  assign w_oob = 1'b0;
`endif

  // Lanes and element addresses handled in the current beat; address wraps modulo DEPTH
  always_comb begin
    for (int j = 0; j < BEAT_ELEMS; j++) begin
      w_lane[j] = c_LIW'(int'(r_beat) * BEAT_ELEMS + j);
      w_ea[j]   = r_addr + c_AW'(int'(r_beat) * BEAT_ELEMS + j);
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (w_acc && !bus.vecOp && bus.we) begin
      r_mem[bus.address] <= bus.wds;
    end
    if (r_state == S_VEC && r_we) begin
      for (int j = 0; j < BEAT_ELEMS; j++) begin
        r_mem[w_ea[j]] <= r_wdv[w_lane[j]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdv   <= '0;
      r_rdv   <= '0;
      r_rds   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (!bus.vecOp) begin
              r_done <= 1'b1;
              if (!bus.we) begin
                r_rds <= r_mem[bus.address];
              end
            end else if (w_oob) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_state <= S_VEC;
              r_busy  <= 1'b1;
              r_beat  <= '0;
              r_we    <= bus.we;
              r_addr  <= bus.address;
              r_wdv   <= bus.wdv;
            end
          end
        end
        S_VEC: begin
          if (!r_we) begin
            for (int j = 0; j < BEAT_ELEMS; j++) begin
              r_rdv[w_lane[j]] <= r_mem[w_ea[j]];
            end
          end
          // done rises together with busy falling, one cycle after the last beat edge
          if (r_beat == c_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_beat  <= '0;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;
  assign bus.rdv  = r_rdv;
  assign bus.rds  = r_rds;

endmodule
`default_nettype wire

// File: tb/tb_vector_memory_access.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vector_memory_access                                            |
// | Table-driven, directed and random checks against a memory model.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_vector_memory_access;

  localparam int LANES  = 8;
  localparam int ELEM_W = 24;
  localparam int DEPTH  = 1024;
  localparam int BEATS  = 4;
  localparam int VW     = LANES * ELEM_W;

  logic clk;
  logic rst_n;

  vector_memory_access_if #(.LANES(LANES), .ELEM_W(ELEM_W), .DEPTH(DEPTH)) bus ();

  vector_memory_access #(
    .LANES(LANES), .ELEM_W(ELEM_W), .DEPTH(DEPTH), .BEAT_ELEMS(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ELEM_W-1:0] mm [DEPTH];
  logic [VW-1:0]     m_rdv;
  logic [ELEM_W-1:0] m_rds;

  typedef struct {
    bit                vec;
    bit                we;
    int                addr;
    logic [VW-1:0]     wdv;
    logic [ELEM_W-1:0] wds;
    logic [VW-1:0]     exp;
  } vec_t;

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkv(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_oob(int a);
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    return (a + LANES - 1) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; request taken at the next posedge, checked at the following negedge
  task automatic do_scalar(bit w, int a, logic [ELEM_W-1:0] d);
    bus.req = 1'b1; bus.we = w; bus.vecOp = 1'b0;
    bus.address = 10'(a); bus.wds = d;
    @(negedge clk);
    bus.req = 1'b0;
    chk1("s_done", bus.done, 1'b1);
    chk1("s_busy", bus.busy, 1'b0);
    chk1("s_err",  bus.err,  1'b0);
    if (w) mm[10'(a)] = d;
    else   m_rds = mm[10'(a)];
    chkv("s_rds", VW'(bus.rds), VW'(m_rds));
    chkv("s_rdv", bus.rdv, m_rdv);
  endtask

  // poke>0 issues a scalar write to address 100 during busy cycle 'poke'
  task automatic do_vec(bit w, int a, logic [VW-1:0] d, int poke);
    bit oob;
    oob = is_oob(a);
    bus.req = 1'b1; bus.we = w; bus.vecOp = 1'b1;
    bus.address = 10'(a); bus.wdv = d;
    @(negedge clk);
    bus.req = 1'b0;
    if (oob) begin
      chk1("oob_done", bus.done, 1'b1);
      chk1("oob_err",  bus.err,  1'b1);
      chk1("oob_busy", bus.busy, 1'b0);
    end else begin
      for (int k = 1; k <= BEATS; k++) begin
        chk1("v_busy", bus.busy, 1'b1);
        chk1("v_done_early", bus.done, 1'b0);
        bus.req = 1'b0;
        if (k == poke) begin
          bus.req = 1'b1; bus.we = 1'b1; bus.vecOp = 1'b0;
          bus.address = 10'd100; bus.wds = 24'hDEAD01;
        end
        @(negedge clk);
      end
      bus.req = 1'b0;
      chk1("v_busy_end", bus.busy, 1'b0);
      chk1("v_done",     bus.done, 1'b1);
      chk1("v_err",      bus.err,  1'b0);
      for (int i = 0; i < LANES; i++) begin
        if (w) mm[10'(a + i)] = d[i*ELEM_W +: ELEM_W];
        else   m_rdv[i*ELEM_W +: ELEM_W] = mm[10'(a + i)];
      end
    end
    chkv("v_rdv", bus.rdv, m_rdv);
    chkv("v_rds", VW'(bus.rds), VW'(m_rds));
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = ELEM_W'($urandom);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t          tbl [7];
    logic [VW-1:0] ramp;
    logic [VW-1:0] d;

    for (int i = 0; i < LANES; i++) ramp[i*ELEM_W +: ELEM_W] = ELEM_W'(i + 1);
    tbl[0] = '{vec:0, we:1, addr:5,    wdv:'0,   wds:24'h00ABCD, exp:'0};
    tbl[1] = '{vec:0, we:0, addr:5,    wdv:'0,   wds:'0,         exp:VW'(24'h00ABCD)};
    tbl[2] = '{vec:1, we:1, addr:16,   wdv:ramp, wds:'0,         exp:'0};
    tbl[3] = '{vec:1, we:0, addr:16,   wdv:'0,   wds:'0,         exp:ramp};
    tbl[4] = '{vec:0, we:0, addr:19,   wdv:'0,   wds:'0,         exp:VW'(24'h000004)};
    tbl[5] = '{vec:0, we:1, addr:1023, wdv:'0,   wds:24'hFFFFFF, exp:'0};
    tbl[6] = '{vec:0, we:0, addr:1023, wdv:'0,   wds:'0,         exp:VW'(24'hFFFFFF)};

    rst_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.vecOp = 1'b0;
    bus.address = '0; bus.wdv = '0; bus.wds = '0;
    m_rdv = '0; m_rds = '0;
    repeat (2) @(negedge clk);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_err",  bus.err,  1'b0);
    chkv("rst_rdv",  bus.rdv,  '0);
    chkv("rst_rds",  VW'(bus.rds), '0);
    rst_n = 1'b1;

    for (int a = 0; a < DEPTH; a++) do_scalar(1'b1, a, ELEM_W'($urandom | 1));

    for (int t = 0; t < 7; t++) begin
      if (tbl[t].vec) do_vec(tbl[t].we, tbl[t].addr, tbl[t].wdv, 0);
      else            do_scalar(tbl[t].we, tbl[t].addr, tbl[t].wds);
      if (!tbl[t].we) begin
        if (tbl[t].vec) chkv("tbl_rdv", bus.rdv, tbl[t].exp);
        else            chkv("tbl_rds", VW'(bus.rds), tbl[t].exp);
      end
    end

    // Request while busy must vanish: memory at 100 unchanged and no stray done
    do_vec(1'b1, 200, rand_vec(), 2);
    @(negedge clk);
    chk1("no_extra_done", bus.done, 1'b0);
    do_scalar(1'b0, 100, '0);

    // Vector write straddling the top of memory
    for (int i = 0; i < LANES; i++) d[i*ELEM_W +: ELEM_W] = ELEM_W'(24'h100 + i);
    do_vec(1'b1, 1020, d, 0);
    for (int i = 0; i < LANES; i++) begin
      do_scalar(1'b0, (1020 + i) % DEPTH, '0);
`ifndef MEM_ACCESS_BOUNDS_CHECK_EN
      chkv("wrap", VW'(bus.rds), VW'(24'h100 + i));
`endif
    end

    // Reset in the middle of a vector write at base 32
    do_vec(1'b0, 40, '0, 0);
    do_scalar(1'b0, 7, '0);
    d = rand_vec();
    bus.req = 1'b1; bus.we = 1'b1; bus.vecOp = 1'b1; bus.address = 10'd32; bus.wdv = d;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk1("ar_busy", bus.busy, 1'b0);
    chk1("ar_done", bus.done, 1'b0);
    chkv("ar_rdv",  bus.rdv,  '0);
    chkv("ar_rds",  VW'(bus.rds), '0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mm[32 + i] = d[i*ELEM_W +: ELEM_W];
    m_rdv = '0; m_rds = '0;
    for (int i = 0; i < LANES; i++) do_scalar(1'b0, 32 + i, '0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_vec(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), rand_vec(), 0);
      else
        do_scalar(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), ELEM_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
